// File: rtl/dcalc_merge_pipe.sv
// Multi-channel merge pipeline. Each input channel has a one-entry holding
// stage. Stages drain into a small output FIFO, either round-robin (PASS) or all together as a bitwise merge.
module dcalc_merge_pipe #(
  parameter int WIDTH = 4,
  parameter int NCH   = 2,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  input  logic [1:0]             mode,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            xfer_count
);

  localparam int RRW = $clog2(NCH);
  localparam int AW  = $clog2(DEPTH);

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_OR   = 2'd1;
  localparam logic [1:0] MODE_AND  = 2'd2;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] stg_data_q [NCH];
  logic [NCH-1:0]   stg_vld_q, stg_vld_d;
  logic [NCH-1:0]   stg_pop, stg_load;
  logic [RRW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [WIDTH-1:0] fifo_mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]      xfer_count_q, xfer_count_d;

  logic             fifo_empty, fifo_full, fifo_pop, fifo_push, fifo_can_accept;
  logic [WIDTH-1:0] push_data, or_all, and_all;
  logic             found;

  // The extra pointer bit separates full (MSBs differ) from empty (equal).
  assign fifo_empty      = (wr_ptr_q == rd_ptr_q);
  assign fifo_full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                           (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_valid       = !fifo_empty;
  assign out_data        = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_pop        = out_valid & out_ready;
  assign fifo_can_accept = !fifo_full | fifo_pop;
  assign xfer_count      = xfer_count_q;

  always_comb begin
    or_all  = '0;
    and_all = '1;
    for (int c = 0; c < NCH; c++) begin
      or_all  = or_all | stg_data_q[c];
      and_all = and_all & stg_data_q[c];
    end
  end

  // PASS searches from rr_ptr upward, then wraps to the channels below it.
  always_comb begin
    stg_pop   = '0;
    rr_ptr_d  = rr_ptr_q;
    fifo_push = 1'b0;
    push_data = '0;
    found     = 1'b0;
    if (mode == MODE_PASS) begin
      if (fifo_can_accept) begin
        for (int c = 0; c < NCH; c++) begin
          if (!found && stg_vld_q[c] && (c >= int'(rr_ptr_q))) begin
            found      = 1'b1;
            stg_pop[c] = 1'b1;
            push_data  = stg_data_q[c];
            rr_ptr_d   = (c == NCH - 1) ? '0 : RRW'(c + 1);
          end
        end
        for (int c = 0; c < NCH; c++) begin
          if (!found && stg_vld_q[c] && (c < int'(rr_ptr_q))) begin
            found      = 1'b1;
            stg_pop[c] = 1'b1;
            push_data  = stg_data_q[c];
            rr_ptr_d   = RRW'(c + 1);
          end
        end
        fifo_push = found;
      end
    end else if ((&stg_vld_q) && fifo_can_accept) begin
      stg_pop   = '1;
      fifo_push = 1'b1;
      if (mode == MODE_OR) begin
        push_data = or_all;
      end else if (mode == MODE_AND) begin
        push_data = and_all;
      end else begin
        push_data = ~or_all;
      end
    end
  end

  assign in_ready     = ~stg_vld_q | stg_pop;
  assign stg_load     = in_valid & in_ready;
  assign stg_vld_d    = (stg_vld_q & ~stg_pop) | stg_load;
  assign wr_ptr_d     = fifo_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
  assign rd_ptr_d     = fifo_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  assign xfer_count_d = fifo_pop  ? (xfer_count_q + 16'd1) : xfer_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld_q    <= '0;
      rr_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      xfer_count_q <= '0;
    end else begin
      stg_vld_q    <= stg_vld_d;
      rr_ptr_q     <= rr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  // Data storage is qualified by the flags and pointers, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (stg_load[c]) begin
        stg_data_q[c] <= in_data[c*WIDTH +: WIDTH];
      end
    end
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: tb/tb_dcalc_merge_pipe.sv
// Randomised and directed bench for dcalc_merge_pipe (WIDTH=4, NCH=2, DEPTH=2),
// checked against a queue-based behavioural model of the merge pipeline.
module tb_dcalc_merge_pipe;

  localparam int WIDTH = 4;
  localparam int NCH   = 2;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       in_data = '0;
  logic [1:0]       in_valid = '0;
  logic [1:0]       in_ready;
  logic [1:0]       mode = '0;
  logic [3:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      xfer_count;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state.
  bit   [1:0] mOcc;
  logic [3:0] mStg [NCH];
  logic [3:0] mFifo [$];
  int         mRr;
  int         mCnt;
  logic [3:0] seenQ [$];

  dcalc_merge_pipe #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_count(xfer_count)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelClear();
    mOcc = '0;
    mFifo.delete();
    mRr  = 0;
    mCnt = 0;
    seenQ.delete();
  endtask

  task automatic doReset();
    in_valid = '0;
    rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_xfer_count", xfer_count, 16'h0000);
    checkOutput("rst_in_ready", in_ready, 2'b11);
    modelClear();
    @(posedge clk);
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic applyStimulus(input logic [1:0] v, input logic [7:0] d,
                               input logic [1:0] md, input logic ordy);
    bit         fpop, acc, push, found;
    logic [3:0] pval, orv, andv;
    logic [1:0] popm, expRdy;
    int         nRr, idx;
    @(negedge clk);
    rst = 1'b0;
    in_valid = v; in_data = d; mode = md; out_ready = ordy;
    #1;
    fpop = (mFifo.size() > 0) && ordy;
    acc  = (mFifo.size() < DEPTH) || fpop;
    popm = '0; push = 0; found = 0; pval = '0; nRr = mRr;
    if (md == 2'd0) begin
      if (acc) begin
        for (int i = 0; i < NCH; i++) begin
          idx = (mRr + i) % NCH;
          if (!found && mOcc[idx]) begin
            found = 1; popm[idx] = 1'b1; pval = mStg[idx];
            nRr = (idx + 1) % NCH; push = 1;
          end
        end
      end
    end else if (mOcc == 2'b11 && acc) begin
      orv = '0; andv = '1;
      for (int i = 0; i < NCH; i++) begin
        orv = orv | mStg[i];
        andv = andv & mStg[i];
      end
      popm = 2'b11; push = 1;
      pval = (md == 2'd1) ? orv : (md == 2'd2) ? andv : ~orv;
    end
    for (int c = 0; c < NCH; c++) expRdy[c] = !mOcc[c] || popm[c];
    checkOutput("out_valid", out_valid, mFifo.size() > 0);
    if (mFifo.size() > 0) checkOutput("out_data", out_data, mFifo[0]);
    checkOutput("in_ready", in_ready, expRdy);
    checkOutput("xfer_count", xfer_count, mCnt);
    if (fpop) seenQ.push_back(out_data);
    @(posedge clk);
    if (fpop) begin
      void'(mFifo.pop_front());
      mCnt = (mCnt + 1) & 16'hFFFF;
    end
    if (push) mFifo.push_back(pval);
    for (int c = 0; c < NCH; c++) begin
      if (v[c] && expRdy[c]) begin
        mOcc[c] = 1'b1; mStg[c] = d[c*WIDTH +: WIDTH];
      end else if (popm[c]) begin
        mOcc[c] = 1'b0;
      end
    end
    mRr = nRr;
  endtask

  initial begin
    #1;
    doReset();

    // PASS: two words accepted together leave on consecutive cycles.
    applyStimulus(2'b11, 8'hA3, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 8'h00, 2'd0, 1'b1);
    #2;
    checkOutput("pass_count", xfer_count, 16'd2);
    checkOutput("pass_first", seenQ[0], 4'h3);
    checkOutput("pass_second", seenQ[1], 4'hA);

    // OR-merge waits for all channels.
    seenQ.delete();
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 8'h85, 2'd1, 1'b1);
    applyStimulus(2'b10, 8'h85, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 8'h00, 2'd1, 1'b1);
    checkOutput("or_words", seenQ.size(), 1);
    checkOutput("or_value", seenQ[0], 4'hD);

    // AND then NOR on the same inputs.
    seenQ.delete();
    applyStimulus(2'b11, 8'h6C, 2'd2, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 8'h00, 2'd2, 1'b1);
    applyStimulus(2'b11, 8'h6C, 2'd3, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 8'h00, 2'd3, 1'b1);
    checkOutput("and_value", seenQ[0], 4'h4);
    checkOutput("nor_value", seenQ[1], 4'h1);

    // Backpressure fills FIFO and stages, then drains in order.
    seenQ.delete();
    for (int i = 0; i < 5; i++)
      applyStimulus(2'b11, {4'(2*i+1), 4'(2*i)}, 2'd0, 1'b0);
    #2;
    checkOutput("bp_in_ready", in_ready, 2'b00);
    checkOutput("bp_out_valid", out_valid, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(2'b00, 8'h00, 2'd0, 1'b1);
    checkOutput("bp_words", seenQ.size(), 4);

    // Stream to the counter wrap point.
    doReset();
    for (int i = 0; i < 70000 && mCnt != 16'hFFFF; i++)
      applyStimulus(2'b11, 8'($urandom), 2'd0, 1'b1);
    #2;
    checkOutput("cnt_ffff", xfer_count, 16'hFFFF);
    for (int i = 0; i < 10 && mCnt != 0; i++)
      applyStimulus(2'b11, 8'($urandom), 2'd0, 1'b1);
    #2;
    checkOutput("cnt_wrap", xfer_count, 16'h0000);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) applyStimulus(2'b11, 8'($urandom), 2'd0, 1'b0);
    applyStimulus(2'b11, 8'($urandom), 2'd0, 1'b1);
    #2;
    checkOutput("full_sim_valid", out_valid, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(2'b00, 8'h00, 2'd0, 1'b0);

    // Mid-transfer reset with a full FIFO.
    for (int i = 0; i < 4; i++) applyStimulus(2'b11, 8'($urandom), 2'd0, 1'b0);
    #2;
    doReset();

    // Random traffic after reset.
    for (int i = 0; i < 1500; i++)
      applyStimulus(2'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dcalc_merge_pipe.md
DCALC_MERGE_PIPE -- requirements
Module: dcalc_merge_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data bits per channel.
REQ-002 The block SHALL have parameter NCH, default 2, giving the number of input channels (range 2..8).
REQ-003 The block SHALL have parameter DEPTH, default 2, giving the output FIFO entries (power of 2, >=2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all flops SHALL be rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port in_data, input, NCH*WIDTH bits: channel c occupies bits [c*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid, input, NCH bits: per-channel valid.
REQ-008 The block SHALL have port in_ready, output, NCH bits: per-channel ready.
REQ-009 The block SHALL have port mode, input, 2 bits: 0 PASS, 1 OR-merge, 2 AND-merge, 3 NOR-merge.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: the FIFO head.
REQ-011 The block SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer ready.
REQ-013 The block SHALL have port xfer_count, output, 16 bits: count of completed output handshakes.

Function
REQ-014 Each channel SHALL own one stage-1 holding register (data plus occupied flag); in_ready[c] SHALL be 1 when stage c is empty or is popped in the same cycle.
REQ-015 An input handshake (in_valid[c] & in_ready[c]) at an edge SHALL load stage c at that edge.
REQ-016 Mode SHALL be sampled combinationally each cycle; a mode change SHALL affect only that cycle's pop decision, never data already in the FIFO.
REQ-017 PASS mode: when the FIFO can accept, the block SHALL pop exactly one occupied stage, chosen round-robin starting at rr_ptr, and write its data to the FIFO.
REQ-018 rr_ptr (width clog2(NCH)) SHALL advance to (granted+1) mod NCH after a PASS grant, and SHALL hold otherwise.
REQ-019 Merge modes: a pop SHALL occur only when all NCH stages are occupied and the FIFO can accept; all stages SHALL then pop together.
REQ-020 The merge write value SHALL be the bitwise OR of all stages (mode 1), the bitwise AND (mode 2), or the bitwise NOT of the OR (mode 3); rr_ptr SHALL hold.
REQ-021 The FIFO can accept when it is not full, or when it is full and out_ready & out_valid in the same cycle (simultaneous push/pop when full SHALL be allowed, with count unchanged).
REQ-022 Pop when empty SHALL be impossible (out_valid=0); push and pop when empty SHALL NOT bypass: data SHALL appear on out_data the cycle after the write.
REQ-023 Latency SHALL be as follows: an input accepted at edge k, with stages and FIFO empty, SHALL be written at edge k+1, giving out_valid=1 after edge k+1.
REQ-024 Throughput in PASS mode SHALL be one word per cycle with out_ready held at 1.
REQ-025 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 xfer_count SHALL increment by 1 on each out_valid & out_ready edge and SHALL wrap from 0xFFFF to 0x0000.
REQ-027 FIFO read/write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit or by an occupancy counter.

Reset
REQ-028 While rst=1, all stage occupied flags, the FIFO pointers, rr_ptr, and xfer_count SHALL be 0; out_valid SHALL be 0 and in_ready SHALL be all ones.
REQ-029 rst asserted mid-transfer SHALL discard all buffered data immediately, with no partial write surviving.
REQ-030 Data registers need not be reset; out_data is don't-care while out_valid=0.
REQ-031 The first handshake SHALL be accepted at the first rising edge after rst deasserts.

Verification (WIDTH=4, NCH=2, DEPTH=2)
REQ-032 PASS scenario: mode=0, out_ready=1; ch0=0x3 and ch1=0xA are both valid in one cycle. Required: out_data 0x3, then 0xA, on consecutive cycles; xfer_count=2.
REQ-033 OR-merge scenario: mode=1; ch0=0x5 only for 3 cycles, then ch1=0x8. Required: no output until ch1 arrives, then a single word 0xD, with in_ready[0]=0 while waiting.
REQ-034 AND/NOR scenario: mode=2 with inputs 0xC and 0x6 gives 0x4; mode=3 with the same inputs gives 0x1.
REQ-035 Backpressure scenario: out_ready=0 with PASS streaming. Required: FIFO fills to 2, stages fill, in_ready goes to 0; after out_ready=1, order is preserved and no word is lost or duplicated.
REQ-036 Wrap and full scenario: xfer_count preloaded by streaming to 0xFFFF, then one more transfer gives 0x0000; a push and pop in the same cycle when full leaves occupancy at 2.
REQ-037 Reset scenario: assert rst with 2 words in the FIFO. Required: out_valid=0 immediately (asynchronous), xfer_count=0, and post-reset traffic starts clean.
